// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter in front of a shared 4:1 data mux.
// The grant and mux select are registered. The selected input is captured into
// a registered output together with a valid flag. A hold limit caps how long a
// single owner keeps the mux while other requesters are waiting.
module mux_4_1_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        Data_req,
  input  logic [DATA_W-1:0] Data_in0,
  input  logic [DATA_W-1:0] Data_in1,
  input  logic [DATA_W-1:0] Data_in2,
  input  logic [DATA_W-1:0] Data_in3,
  output logic [3:0]        Data_gnt,
  output logic [1:0]        Data_sel,
  output logic [DATA_W-1:0] Data_out,
  output logic              Data_valid
);

  localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         lastOwner_q, lastOwner_d;
  logic [CNT_W-1:0]   holdCnt_q, holdCnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         sel_q, sel_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic               valid_q, valid_d;

  logic [DATA_W-1:0]  selData;
  logic [3:0]         othersReq;
  logic               anyFree, anyOther;
  logic [1:0]         freeWin, otherWin;

  // Scans base+1, base+2, base+3, base+0 (mod 4) and returns {found, index}
  // of the first set request bit, so the most recent owner always comes last.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] base);
    logic       found;
    logic [1:0] win;
    logic [1:0] idx;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // The mux is driven only from the registered select, never from the request inputs.
  always_comb begin
    selData = Data_in0;
    case (sel_q)
      2'd0: selData = Data_in0;
      2'd1: selData = Data_in1;
      2'd2: selData = Data_in2;
      2'd3: selData = Data_in3;
      default: selData = Data_in0;
    endcase
  end

  // Next-state logic: the release check takes precedence over the hold limit, and the hold limit over a normal beat.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lastOwner_d = lastOwner_q;
    holdCnt_d   = holdCnt_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    out_d       = out_q;
    valid_d     = 1'b0;

    othersReq             = Data_req & ~onehot(owner_q);
    {anyFree, freeWin}    = pick(Data_req, lastOwner_q);
    {anyOther, otherWin}  = pick(othersReq, owner_q);

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (anyFree) begin
          owner_d     = freeWin;
          lastOwner_d = freeWin;
          sel_d       = freeWin;
          gnt_d       = onehot(freeWin);
          holdCnt_d   = '0;
          state_d     = GRANT;
        end
      end
      GRANT: begin
        if (!Data_req[owner_q]) begin
          if (anyOther) begin
            owner_d     = otherWin;
            lastOwner_d = otherWin;
            sel_d       = otherWin;
            gnt_d       = onehot(otherWin);
            holdCnt_d   = '0;
          end else begin
            gnt_d   = 4'b0000;
            state_d = IDLE;
          end
        end else begin
          out_d   = selData;
          valid_d = 1'b1;
          if ((holdCnt_q == HOLD_LAST) && anyOther) begin
            owner_d     = otherWin;
            lastOwner_d = otherWin;
            sel_d       = otherWin;
            gnt_d       = onehot(otherWin);
            holdCnt_d   = '0;
          end else if (holdCnt_q != HOLD_LAST) begin
            holdCnt_d = holdCnt_q + 1'b1;
          end
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything at once, so a burst cut by reset leaves no trailing beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      lastOwner_q <= 2'd3;
      holdCnt_q   <= '0;
      gnt_q       <= 4'b0000;
      sel_q       <= 2'd0;
      out_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lastOwner_q <= lastOwner_d;
      holdCnt_q   <= holdCnt_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      out_q       <= out_d;
      valid_q     <= valid_d;
    end
  end

  assign Data_gnt   = gnt_q;
  assign Data_sel   = sel_q;
  assign Data_out   = out_q;
  assign Data_valid = valid_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Directed testbench for mux_4_1_rr_arbiter.
// Expected data beats go into a queue, and a monitor compares each valid beat
// against that queue. Grant and select values are checked directly at each step.
module tb_mux_4_1_rr_arbiter;

  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    Data_req;
  logic [DW-1:0] Data_in0, Data_in1, Data_in2, Data_in3;
  logic [3:0]    Data_gnt;
  logic [1:0]    Data_sel;
  logic [DW-1:0] Data_out;
  logic          Data_valid;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] expQ[$];

  mux_4_1_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Data_req  (Data_req),
    .Data_in0  (Data_in0),
    .Data_in1  (Data_in1),
    .Data_in2  (Data_in2),
    .Data_in3  (Data_in3),
    .Data_gnt  (Data_gnt),
    .Data_sel  (Data_sel),
    .Data_out  (Data_out),
    .Data_valid(Data_valid)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req);
    Data_req = req;
  endtask

  task automatic pushBeats(input logic [DW-1:0] v, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Monitor: each valid beat must match the oldest expected value in the queue.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst_n && Data_valid) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat actual=%0h expected=none at %0t", Data_out, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("beat_data", 32'(Data_out), 32'(e));
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence: reset, single requester, full contention, early release with data path, rotation.
  initial begin
    logic [DW-1:0] v;
    rst_n    = 1'b0;
    Data_req = 4'b1111;
    Data_in0 = 4'hA;
    Data_in1 = 4'h1;
    Data_in2 = 4'hC;
    Data_in3 = 4'h5;

    // Reset held with active requests.
    repeat (3) tick();
    checkOutput("rst_gnt",   32'(Data_gnt),   32'h0);
    checkOutput("rst_sel",   32'(Data_sel),   32'h0);
    checkOutput("rst_out",   32'(Data_out),   32'h0);
    checkOutput("rst_valid", 32'(Data_valid), 32'h0);

    // Release into full contention; requester 0 wins first, then reset hits mid-burst.
    pushBeats(4'hA, 2);
    rst_n = 1'b1;
    tick();
    checkOutput("first_gnt",   32'(Data_gnt),   32'h1);
    checkOutput("first_valid", 32'(Data_valid), 32'h0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_gnt",   32'(Data_gnt),   32'h0);
    checkOutput("midrst_valid", 32'(Data_valid), 32'h0);
    checkOutput("midrst_out",   32'(Data_out),   32'h0);
    @(negedge clk);
    applyStimulus(4'b0000);
    rst_n = 1'b1;

    // Single requester holds past the hold limit.
    applyStimulus(4'b0010);
    tick();
    checkOutput("single_gnt",   32'(Data_gnt),   32'h2);
    checkOutput("single_sel",   32'(Data_sel),   32'h1);
    checkOutput("single_valid", 32'(Data_valid), 32'h0);
    pushBeats(4'h1, 9);
    repeat (9) tick();
    checkOutput("single_hold_gnt",   32'(Data_gnt),   32'h2);
    checkOutput("single_hold_valid", 32'(Data_valid), 32'h1);
    applyStimulus(4'b0000);
    tick();
    checkOutput("single_rel_gnt",   32'(Data_gnt),   32'h0);
    checkOutput("single_rel_valid", 32'(Data_valid), 32'h0);
    checkOutput("single_rel_out",   32'(Data_out),   32'h1);

    // Full contention from reset: order 0,1,2,3,0 with four beats each and no bubbles.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b1111);
    pushBeats(4'hA, 4);
    pushBeats(4'h1, 4);
    pushBeats(4'hC, 4);
    pushBeats(4'h5, 4);
    pushBeats(4'hA, 4);
    tick();
    checkOutput("cont_first_gnt", 32'(Data_gnt), 32'h1);
    for (int k = 2; k <= 21; k++) begin
      tick();
      checkOutput("cont_valid", 32'(Data_valid), 32'h1);
      checkOutput("cont_gnt",   32'(Data_gnt),   32'h1 << (((k - 1) / 4) % 4));
    end
    applyStimulus(4'b0000);
    tick();
    checkOutput("cont_end_gnt", 32'(Data_gnt), 32'h0);

    // Early release: owner 0 drops after two beats while requester 2 waits.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(4'b0101);
    tick();
    checkOutput("early_gnt0", 32'(Data_gnt), 32'h1);
    pushBeats(4'hA, 2);
    tick();
    tick();
    applyStimulus(4'b0100);
    pushBeats(4'hC, 3);
    tick();
    checkOutput("early_valid", 32'(Data_valid), 32'h0);
    checkOutput("early_gnt2",  32'(Data_gnt),   32'h4);
    checkOutput("early_sel",   32'(Data_sel),   32'h2);
    checkOutput("early_out",   32'(Data_out),   32'hA);
    repeat (3) tick();

    // Data path: Data_in2 toggles while the other inputs change freely.
    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 1) ? 4'h3 : 4'hC;
      Data_in2 = v;
      Data_in0 = 4'($urandom);
      Data_in1 = 4'($urandom);
      Data_in3 = 4'($urandom);
      pushBeats(v, 1);
      tick();
      checkOutput("path_sel", 32'(Data_sel), 32'h2);
    end
    Data_in0 = 4'hA;
    Data_in1 = 4'h1;
    Data_in2 = 4'hC;
    Data_in3 = 4'h5;
    applyStimulus(4'b0000);
    tick();
    checkOutput("path_rel_gnt", 32'(Data_gnt), 32'h0);
    checkOutput("path_rel_out", 32'(Data_out), 32'h3);

    // Rotation: last owner was 2, so requester 3 beats requester 0, then 0 follows.
    applyStimulus(4'b1001);
    tick();
    checkOutput("rot_gnt3", 32'(Data_gnt), 32'h8);
    checkOutput("rot_sel3", 32'(Data_sel), 32'h3);
    pushBeats(4'h5, 1);
    tick();
    applyStimulus(4'b0001);
    tick();
    checkOutput("rot_gnt0",  32'(Data_gnt),   32'h1);
    checkOutput("rot_sel0",  32'(Data_sel),   32'h0);
    checkOutput("rot_valid", 32'(Data_valid), 32'h0);
    checkOutput("rot_hold",  32'(Data_out),   32'h5);
    pushBeats(4'hA, 1);
    tick();
    applyStimulus(4'b0000);
    tick();
    checkOutput("rot_end_gnt", 32'(Data_gnt), 32'h0);

    tick();
    checkOutput("queue_empty", 32'(expQ.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux_4_1_rr_arbiter.md
Name: mux_4_1_rr_arbiter

Overview:
Round-robin arbiter that shares the 4:1 data mux between four requesters. It drives the mux select from a registered grant and captures the selected input into a registered output with a valid flag. A per-grant hold limit stops one requester from starving the others. It sits between the four source blocks and the single downstream consumer of the muxed data.

Parameters:
DATA_W, 1, width of each data input and of Data_out.
MAX_HOLD, 4, maximum consecutive valid beats per grant while another requester is waiting. Legal range is 1..16.

Ports:
clk  input  1  single clock; every register updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
Data_req  input  4  bit i is the request from requester i; it is level-sensitive.
Data_in0  input  DATA_W  data from requester 0.
Data_in1  input  DATA_W  data from requester 1.
Data_in2  input  DATA_W  data from requester 2.
Data_in3  input  DATA_W  data from requester 3.
Data_gnt  output  4  one-hot grant; all zero when idle. Registered.
Data_sel  output  2  mux select equal to the current or last owner index. Registered.
Data_out  output  DATA_W  registered output of the mux.
Data_valid  output  1  high when Data_out holds a beat captured this cycle.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low clears Data_gnt=0, Data_sel=0, Data_out=0, Data_valid=0, state=IDLE, hold_cnt=0 and last_owner=3, immediately and without waiting for a clock edge.
  - Reset asserted mid-burst aborts the grant at once; no partial beat is emitted after release.
- State machine: IDLE and GRANT. The internal registers are owner[1:0], last_owner[1:0] and hold_cnt (clog2(MAX_HOLD) bits, minimum 1).
- Winner selection: scan (last_owner+1), (last_owner+2), (last_owner+3), (last_owner+0), all mod 4, and take the first index whose Data_req bit is set. When "others pending" is checked, the current owner is excluded from the scan.
- IDLE, on a rising edge:
  - Data_req==0: stay in IDLE. Data_gnt stays 0, Data_valid=0, Data_sel keeps its value.
  - Data_req!=0: owner, last_owner and Data_sel take the winner; Data_gnt becomes the one-hot of the winner; hold_cnt=0; Data_valid=0; go to GRANT. Grant latency is 1 edge after the request is sampled.
- GRANT, on a rising edge, evaluated in this priority order:
  1. Data_req[owner]==0 (release): Data_valid=0 and Data_out holds its value.
     - If any other request is set, grant the winner (rotating from owner) in the same edge, set hold_cnt=0 and stay in GRANT.
     - Otherwise Data_gnt=0 and go to IDLE.
  2. hold_cnt==MAX_HOLD-1 and another request is pending: Data_out=Data_in[owner] and Data_valid=1 as the final beat. Switch the grant to the winner and set hold_cnt=0. There is no valid bubble; the new owner's first beat lands on the next edge.
  3. Otherwise: Data_out=Data_in[owner] and Data_valid=1. hold_cnt increments, saturating at MAX_HOLD-1, so a lone requester holds the grant indefinitely.
- Beat count: with contention, each owner receives exactly MAX_HOLD valid beats per grant.
- Mux path: Data_out always samples Data_in[Data_sel] from the registered select; the input-to-output latency is 1 edge.
- Data_out retains its last value whenever Data_valid=0.
- Data_sel is never X and always equals the index of Data_gnt when Data_gnt is nonzero.
- Simultaneous requests are resolved only by the rotating order above; no requester has fixed priority.
- Invariant: Data_gnt has at most one bit set.

Test Plan:
1. Reset: hold rst_n=0 with arbitrary inputs -> all outputs 0. Assert rst_n=0 between edges during a burst -> Data_gnt=0000 and Data_valid=0 immediately.
2. Single requester: Data_req=0010, Data_in1=1 for 10 edges -> edge 1 gives Data_gnt=0010, Data_sel=01, Data_valid=0. Edges 2..10 give Data_valid=1, Data_out=1, and the grant holds past MAX_HOLD.
3. Full contention: Data_req=1111 held, MAX_HOLD=4 -> grant order 0,1,2,3,0. Each owner gets 4 consecutive valid beats, and Data_valid stays continuously 1 after the first beat.
4. Early release: owner 0 drops its request after 2 beats while req2=1 -> one edge with Data_valid=0 and Data_gnt=0100, then beats from Data_in2.
5. Rotation fairness: last_owner=2, back in IDLE, Data_req=1001 applied -> requester 3 wins (Data_sel=11). After requester 3 releases, requester 0 wins.
6. Data path: requester 2 granted with Data_in2 toggling each cycle -> Data_out follows Data_in2 delayed by 1 edge, and changes on Data_in0/1/3 have no effect.
